// File: rtl/vga_frame_fetch_if.sv
// Frame-store read port and Sobel buffer-swap handshake of the VGA pixel fetch stage.
// The master side is the fetch stage; the slave side is the frame store plus the Sobel engine.
interface vga_frame_fetch_if;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic [7:0]  rd_data;
  logic        swap_req;
  logic        swap_ack;
  logic        buf_sel;

  modport master (output rd_en, rd_addr, swap_ack, buf_sel, input rd_data, swap_req);
  modport slave  (input rd_en, rd_addr, swap_ack, buf_sel, output rd_data, swap_req);
endinterface

// File: rtl/vga_frame_fetch.sv
// Maps visible VGA pixels into a grayscale image window read from a double-buffered
// frame store; colour and syncs leave through the same two pixel-strobe stages.
module vga_frame_fetch #(
  parameter int          X0     = 192,
  parameter int          Y0     = 112,
  parameter int          IMG_WB = 8,
  parameter int          IMG_HB = 8,
  parameter int          VLINES = 480,
  parameter logic [11:0] BORDER = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic              blank,
  input  logic              hs_in,
  input  logic              vs_in,
  vga_frame_fetch_if.master fs,
  output logic [11:0]       rgb,
  output logic              hs_out,
  output logic              vs_out
);
  localparam int AW = 1 + IMG_HB + IMG_WB;

  logic [11:0]       hx, vy;
  logic [IMG_WB-1:0] x;
  logic [IMG_HB-1:0] y;
  logic              in_win, swap_pt;

  logic          rd_en_d, rd_en_q;
  logic [AW-1:0] rd_addr_d, rd_addr_q;
  logic [7:0]    pix_d, pix_q;
  logic          blank_a_d, blank_a_q, win_a_d, win_a_q;
  logic          hs_a_d, hs_a_q, vs_a_d, vs_a_q;
  logic [11:0]   rgb_d, rgb_q;
  logic          hs_out_d, hs_out_q, vs_out_d, vs_out_q;
  logic          buf_sel_d, buf_sel_q, swap_ack_d, swap_ack_q;

  // 12-bit offsets: a negative offset can only occur outside the window, so truncation is safe
  assign hx      = {1'b0, hcount};
  assign vy      = {1'b0, vcount};
  assign x       = IMG_WB'(hx - 12'(X0));
  assign y       = IMG_HB'(vy - 12'(Y0));
  assign in_win  = !blank
                && (hx >= 12'(X0)) && (hx < 12'(X0 + (1 << IMG_WB)))
                && (vy >= 12'(Y0)) && (vy < 12'(Y0 + (1 << IMG_HB)));
  assign swap_pt = (hcount == 11'(0)) && (vcount == 11'(VLINES));

  always_comb begin
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    pix_d      = rd_en_q ? fs.rd_data : pix_q;
    blank_a_d  = blank_a_q;
    win_a_d    = win_a_q;
    hs_a_d     = hs_a_q;
    vs_a_d     = vs_a_q;
    rgb_d      = rgb_q;
    hs_out_d   = hs_out_q;
    vs_out_d   = vs_out_q;
    buf_sel_d  = buf_sel_q;
    swap_ack_d = 1'b0;
    if (pix_ce) begin
      blank_a_d = blank;
      win_a_d   = in_win;
      hs_a_d    = hs_in;
      vs_a_d    = vs_in;
      if (in_win) begin
        rd_en_d   = 1'b1;
        rd_addr_d = {buf_sel_q, y, x};
      end
      rgb_d    = blank_a_q ? 12'h000 : win_a_q ? {3{pix_q[7:4]}} : BORDER;
      hs_out_d = hs_a_q;
      vs_out_d = vs_a_q;
      // swap point sits in vertical blank, so no visible fetch ever sees buf_sel change
      if (swap_pt && fs.swap_req) begin
        buf_sel_d  = ~buf_sel_q;
        swap_ack_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      pix_q      <= '0;
      blank_a_q  <= 1'b1;
      win_a_q    <= 1'b0;
      hs_a_q     <= 1'b1;
      vs_a_q     <= 1'b1;
      rgb_q      <= '0;
      hs_out_q   <= 1'b1;
      vs_out_q   <= 1'b1;
      buf_sel_q  <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      pix_q      <= pix_d;
      blank_a_q  <= blank_a_d;
      win_a_q    <= win_a_d;
      hs_a_q     <= hs_a_d;
      vs_a_q     <= vs_a_d;
      rgb_q      <= rgb_d;
      hs_out_q   <= hs_out_d;
      vs_out_q   <= vs_out_d;
      buf_sel_q  <= buf_sel_d;
      swap_ack_q <= swap_ack_d;
    end
  end

  assign fs.rd_en    = rd_en_q;
  assign fs.rd_addr  = rd_addr_q;
  assign fs.swap_ack = swap_ack_q;
  assign fs.buf_sel  = buf_sel_q;
  assign rgb         = rgb_q;
  assign hs_out      = hs_out_q;
  assign vs_out      = vs_out_q;
endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch: a frame-store model feeds reads and a queue
// holds the colour/sync each pixel should produce two strobes later.
module tb_vga_frame_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic [10:0] hcount = '0, vcount = '0;
  logic        blank = 1'b1, hs_in = 1'b1, vs_in = 1'b1;
  logic [11:0] rgb;
  logic        hs_out, vs_out;

  vga_frame_fetch_if fs ();

  vga_frame_fetch dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount),
    .blank(blank), .hs_in(hs_in), .vs_in(vs_in), .fs(fs),
    .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic m_buf = 1'b0;

  function automatic logic [7:0] gray(input logic [16:0] a);
    int s;
    s = 'hA5 + 17 * int'(a[7:0]) + 5 * int'(a[15:8]) + (a[16] ? 'h40 : 0);
    return 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One pixel strobe followed by one idle clock (strobe spacing of 2 clk)
  task automatic pix(input int h, input int v, input bit b, input bit hs, input bit vs);
    bit          win, sw;
    logic [16:0] ea;
    logic [7:0]  g;
    exp_t        e;
    win = !b && h >= 192 && h < 448 && v >= 112 && v < 368;
    ea  = {m_buf, 8'(v - 112), 8'(h - 192)};
    g   = gray(ea);
    sw  = (h == 0) && (v == 480) && (fs.swap_req === 1'b1);
    hcount = 11'(h); vcount = 11'(v); blank = b; hs_in = hs; vs_in = vs;
    pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    if (sw) m_buf = ~m_buf;
    chk("rd_en", 32'(fs.rd_en), 32'(win));
    if (win) begin
      chk("rd_addr", 32'(fs.rd_addr), 32'(ea));
      fs.rd_data = g;
    end
    chk("swap_ack", 32'(fs.swap_ack), 32'(sw));
    chk("buf_sel", 32'(fs.buf_sel), 32'(m_buf));
    e.rgb = b ? 12'h000 : win ? {3{g[7:4]}} : 12'h000;
    e.hs  = hs;
    e.vs  = vs;
    exp_q.push_back(e);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("rgb", 32'(rgb), 32'(e.rgb));
      chk("hs_out", 32'(hs_out), 32'(e.hs));
      chk("vs_out", 32'(vs_out), 32'(e.vs));
    end
    @(posedge clk); #1;
    fs.rd_data = 8'h00;
    chk("rd_en_pulse", 32'(fs.rd_en), 32'(0));
    chk("swap_ack_pulse", 32'(fs.swap_ack), 32'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rgb"}, 32'(rgb), 32'(0));
    chk({tag, "_hs"}, 32'(hs_out), 32'(1));
    chk({tag, "_vs"}, 32'(vs_out), 32'(1));
    chk({tag, "_buf"}, 32'(fs.buf_sel), 32'(0));
    chk({tag, "_rd_en"}, 32'(fs.rd_en), 32'(0));
    chk({tag, "_rd_addr"}, 32'(fs.rd_addr), 32'(0));
    chk({tag, "_ack"}, 32'(fs.swap_ack), 32'(0));
  endtask

  initial begin
    fs.rd_data  = 8'h00;
    fs.swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // image origin, left border, first pixels
    pix(190, 112, 0, 1, 1);
    pix(191, 112, 0, 1, 1);
    pix(192, 112, 0, 1, 1);
    pix(193, 112, 0, 1, 1);
    pix(194, 112, 0, 1, 1);
    // bottom-right corner and right border
    pix(446, 367, 0, 1, 1);
    pix(447, 367, 0, 1, 1);
    pix(448, 367, 0, 1, 1);
    pix(449, 367, 0, 1, 1);
    // blanked pixels inside window coordinates, with hs/vs pulses
    pix(198, 120, 1, 1, 1);
    pix(199, 120, 1, 0, 1);
    pix(200, 120, 1, 1, 1);
    pix(201, 120, 1, 1, 0);
    pix(202, 120, 0, 1, 1);
    pix(203, 120, 0, 1, 1);

    // swap requested during line 479
    fs.swap_req = 1'b1;
    pix(639, 479, 1, 1, 1);
    pix(0, 480, 1, 1, 1);
    pix(1, 480, 1, 1, 1);
    fs.swap_req = 1'b0;
    // next frame reads from buffer 1
    pix(192, 112, 0, 1, 1);
    pix(193, 112, 0, 1, 1);
    pix(300, 200, 0, 1, 1);
    // a frame without request: no swap
    pix(0, 480, 1, 1, 1);
    pix(250, 150, 0, 1, 1);
    pix(251, 150, 0, 0, 0);

    // asynchronous reset mid-line
    #3 rst = 1'b1;
    #1;
    chk_reset_state("midreset");
    m_buf = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // request rising on the swap cycle itself, then held across two frames
    pix(10, 479, 1, 1, 1);
    fs.swap_req = 1'b1;
    pix(0, 480, 1, 1, 1);
    pix(192, 113, 0, 1, 1);
    pix(0, 480, 1, 1, 1);
    fs.swap_req = 1'b0;
    pix(320, 240, 0, 1, 1);
    pix(321, 240, 0, 1, 1);
    pix(700, 240, 1, 1, 1);
    pix(701, 240, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
